// File: rtl/ctrl_seq_pkg.sv
// Shared constants and types for the control-word issue sequencer.
package ctrl_seq_pkg;

  localparam int IW       = 7;
  localparam int CW       = 26;
  localparam int MARK_BIT = 23;
  localparam int BEAT_MSB = 6;
  localparam int BEAT_LSB = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_e;

  typedef logic [1:0] beat_t;

  // Opcode bits [6:5] carry the beat count minus one.
  function automatic beat_t beat_field(input logic [IW-1:0] op);
    return op[BEAT_MSB:BEAT_LSB];
  endfunction

endpackage

// File: rtl/ctrl_issue_sequencer_if.sv
// Opcode intake, decoder drive/return and control-word issue signals of the sequencer.
interface ctrl_issue_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int IW    = ctrl_seq_pkg::IW,
  parameter int CW    = ctrl_seq_pkg::CW
);
  import ctrl_seq_pkg::*;

  logic                     flush;
  logic                     op_valid;
  logic                     op_ready;
  logic [IW-1:0]            op_data;
  logic [IW-1:0]            dec_opcode;
  logic [CW-1:0]            dec_word;
  logic                     cw_valid;
  logic                     cw_ready;
  logic [CW-1:0]            cw_data;
  beat_t                    cw_beat;
  logic                     cw_last;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     mark_err;

  modport master (
    input  flush, op_valid, op_data, dec_word, cw_ready,
    output op_ready, dec_opcode, cw_valid, cw_data, cw_beat, cw_last, fifo_count, mark_err
  );

  modport slave (
    output flush, op_valid, op_data, dec_word, cw_ready,
    input  op_ready, dec_opcode, cw_valid, cw_data, cw_beat, cw_last, fifo_count, mark_err
  );

endinterface

// File: rtl/ctrl_op_fifo.sv
// Opcode FIFO: DEPTH x IW, synchronous flush, combinational head (zero when empty).
module ctrl_op_fifo #(
  parameter int DEPTH = 4,
  parameter int IW    = ctrl_seq_pkg::IW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [IW-1:0]          push_data,
  input  logic                   pop,
  output logic [IW-1:0]          head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  import ctrl_seq_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full  = count_q[PW];
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ctrl_issue_sequencer.sv
// Buffers opcodes, drives the external decoder and issues each control word for 1-4 beats.
// Optional FIFO bypass for a 1-cycle idle latency: define CTRL_SEQ_BYPASS_EN.
module ctrl_issue_sequencer #(
  parameter int DEPTH    = 4,
  parameter int IW       = ctrl_seq_pkg::IW,
  parameter int CW       = ctrl_seq_pkg::CW,
  parameter int MARK_BIT = ctrl_seq_pkg::MARK_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  ctrl_issue_sequencer_if.master bus
);
  import ctrl_seq_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [IW-1:0]    fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;

  logic             op_ready, op_acc, hs, slot_free, byp_sel;
  logic             load_fifo, load_byp, load, push, pop;
  logic [IW-1:0]    dec_op;
  beat_t            load_beats;

  seq_state_e       state_q, state_d;
  logic             cw_valid_q, cw_valid_d;
  logic             cw_last_q, cw_last_d;
  logic             mark_err_q, mark_err_d;
  logic [CW-1:0]    cw_data_q, cw_data_d;
  beat_t            cw_beat_q, cw_beat_d;
  beat_t            beats_left_q, beats_left_d;

  ctrl_op_fifo #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .push      (push),
    .push_data (bus.op_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // Intake is closed while reset is held and during a flush cycle.
  assign op_ready = !rst && !bus.flush && !fifo_full;

  always_comb begin
    op_acc    = bus.op_valid && op_ready;
    hs        = cw_valid_q && bus.cw_ready;
    slot_free = (state_q == IDLE) || (hs && cw_last_q);
`ifdef CTRL_SEQ_BYPASS_EN
    byp_sel   = slot_free && fifo_empty;
`else
    byp_sel   = 1'b0;
`endif
    dec_op     = byp_sel ? bus.op_data : fifo_head;
    load_fifo  = !bus.flush && slot_free && !fifo_empty;
    load_byp   = !bus.flush && byp_sel && op_acc;
    load       = load_fifo || load_byp;
    push       = op_acc && !load_byp;
    pop        = load_fifo;
    load_beats = beat_field(dec_op);
  end

  always_comb begin
    state_d      = state_q;
    cw_valid_d   = cw_valid_q;
    cw_data_d    = cw_data_q;
    cw_beat_d    = cw_beat_q;
    cw_last_d    = cw_last_q;
    beats_left_d = beats_left_q;
    mark_err_d   = mark_err_q;
    if (bus.flush) begin
      state_d    = IDLE;
      cw_valid_d = 1'b0;
      cw_beat_d  = '0;
      cw_last_d  = 1'b0;
    end else if (load) begin
      // Covers both the idle start and the bubble-free follow-on after a last beat.
      state_d      = ISSUE;
      cw_valid_d   = 1'b1;
      cw_data_d    = bus.dec_word;
      cw_beat_d    = '0;
      beats_left_d = load_beats;
      cw_last_d    = (load_beats == '0);
      mark_err_d   = mark_err_q || !bus.dec_word[MARK_BIT];
    end else if (hs && cw_last_q) begin
      state_d    = IDLE;
      cw_valid_d = 1'b0;
      cw_last_d  = 1'b0;
    end else if (hs) begin
      cw_beat_d = cw_beat_q + 2'd1;
      cw_last_d = ((cw_beat_q + 2'd1) == beats_left_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cw_valid_q   <= 1'b0;
      cw_data_q    <= '0;
      cw_beat_q    <= '0;
      cw_last_q    <= 1'b0;
      beats_left_q <= '0;
      mark_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cw_valid_q   <= cw_valid_d;
      cw_data_q    <= cw_data_d;
      cw_beat_q    <= cw_beat_d;
      cw_last_q    <= cw_last_d;
      beats_left_q <= beats_left_d;
      mark_err_q   <= mark_err_d;
    end
  end

  assign bus.op_ready   = op_ready;
  assign bus.dec_opcode = dec_op;
  assign bus.cw_valid   = cw_valid_q;
  assign bus.cw_data    = cw_data_q;
  assign bus.cw_beat    = cw_beat_q;
  assign bus.cw_last    = cw_last_q;
  assign bus.fifo_count = fifo_cnt;
  assign bus.mark_err   = mark_err_q;

endmodule

// File: tb/tb_ctrl_issue_sequencer.sv
// Self-checking bench for ctrl_issue_sequencer: directed scenarios plus random traffic
// against a queue-based transaction model of the sequencer.
module tb_ctrl_issue_sequencer;
  import ctrl_seq_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_mz = 1'b0;
  always #5 clk = ~clk;

  ctrl_issue_sequencer_if #(.DEPTH(DEPTH)) bus ();
  ctrl_issue_sequencer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Stand-in decoder: fixed mixing of the opcode with the marker bit forced to 1.
  function automatic logic [25:0] dec_fn(input logic [6:0] x);
    logic [25:0] y;
    y     = {x, ~x, x ^ 7'h2B, x[4:0]};
    y[23] = 1'b1;
    return y;
  endfunction

  always_comb begin
    bus.dec_word = dec_fn(bus.dec_opcode);
    if (force_mz) bus.dec_word[23] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Transaction model: queue of accepted-but-unloaded opcodes plus the word being issued.
  logic [6:0]  mq[$];
  bit          cur_v = 0;
  int          cur_beat = 0;
  int          cur_nb = 1;
  logic [25:0] m_data = '0;
  bit          m_mark = 0;
  int          hs_count = 0;
  int          cyc = 0;
  int          hs_cyc[$];

  task automatic mload(input logic [6:0] op);
    cur_v    = 1;
    cur_beat = 0;
    cur_nb   = int'(op[6:5]) + 1;
    m_data   = dec_fn(op);
    if (force_mz) begin
      m_data[23] = 1'b0;
      m_mark     = 1;
    end
  endtask

  always @(negedge clk) begin : cmp
    bit acc, hs, freeing, used;
    cyc++;
    if (rst) begin
      mq.delete();
      cur_v = 0; cur_beat = 0; cur_nb = 1; m_data = '0; m_mark = 0;
      check("rst_op_ready", bus.op_ready, 0);
      check("rst_cw_valid", bus.cw_valid, 0);
      check("rst_cw_data", bus.cw_data, 0);
      check("rst_fifo_count", bus.fifo_count, 0);
      check("rst_mark_err", bus.mark_err, 0);
`ifndef CTRL_SEQ_BYPASS_EN
      check("rst_dec_opcode", bus.dec_opcode, 0);
`endif
    end else begin
      check("cw_valid", bus.cw_valid, cur_v);
      check("cw_data", bus.cw_data, m_data);
      if (cur_v) begin
        check("cw_beat", bus.cw_beat, cur_beat);
        check("cw_last", bus.cw_last, (cur_beat == cur_nb - 1));
      end else begin
        check("cw_last_idle", bus.cw_last, 0);
      end
      check("fifo_count", bus.fifo_count, mq.size());
      check("op_ready", bus.op_ready, (!bus.flush && mq.size() < DEPTH));
      check("mark_err", bus.mark_err, m_mark);
      if (mq.size() != 0) check("dec_opcode", bus.dec_opcode, mq[0]);
`ifndef CTRL_SEQ_BYPASS_EN
      else check("dec_opcode_empty", bus.dec_opcode, 0);
`endif
      // Advance the model to what the coming edge must produce.
      acc  = bus.op_valid && !bus.flush && (mq.size() < DEPTH);
      hs   = cur_v && bus.cw_ready;
      used = 0;
      if (hs) begin
        hs_count++;
        hs_cyc.push_back(cyc);
      end
      if (bus.flush) begin
        mq.delete();
        cur_v = 0;
        cur_beat = 0;
      end else begin
        freeing = !cur_v || (hs && cur_beat == cur_nb - 1);
        if (hs && cur_beat != cur_nb - 1) cur_beat++;
        if (freeing) begin
          if (mq.size() != 0) mload(mq.pop_front());
`ifdef CTRL_SEQ_BYPASS_EN
          else if (acc) begin
            mload(bus.op_data);
            used = 1;
          end
`endif
          else cur_v = 0;
        end
        if (acc && !used) mq.push_back(bus.op_data);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_op(input logic [6:0] op);
    int n = 0;
    bit took = 0;
    bus.op_valid = 1'b1;
    bus.op_data  = op;
    while (!took && n < 100) begin
      took = bus.op_ready;
      tick();
      n++;
    end
    bus.op_valid = 1'b0;
    check("push_accept", took, 1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.cw_valid && n < 50) begin
      tick();
      n++;
    end
    check(name, bus.cw_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    bus.op_valid = 1'b0;
    bus.cw_ready = 1'b1;
    while ((bus.cw_valid || bus.fifo_count != 0) && n < 300) begin
      tick();
      n++;
    end
    check("drain_idle", bus.cw_valid, 0);
  endtask

  initial begin : stim
    int base, base_idx;
    bus.flush = 1'b0; bus.op_valid = 1'b0; bus.op_data = '0; bus.cw_ready = 1'b0;

    check("model_dec_05", dec_fn(7'h05), 26'h0AFA5C5);
    check("model_dec_00", dec_fn(7'h00), 26'h087F560);

    tick(3);
    check("reset_op_ready", bus.op_ready, 0);
    check("reset_fifo_count", bus.fifo_count, 0);
    rst = 1'b0;
    #1 check("post_reset_op_ready", bus.op_ready, 1);
    tick();

    // Single 1-beat op.
    bus.cw_ready = 1'b1;
    bus.op_valid = 1'b1;
    bus.op_data  = 7'h05;
    tick();
    bus.op_valid = 1'b0;
`ifndef CTRL_SEQ_BYPASS_EN
    check("lat_not_yet", bus.cw_valid, 0);
    tick();
`endif
    check("lat_valid", bus.cw_valid, 1);
    check("single_data", bus.cw_data, 26'h0AFA5C5);
    check("single_last", bus.cw_last, 1);
    check("single_mark", bus.mark_err, 0);
    tick();
    check("single_done", bus.cw_valid, 0);

    // Four beats under alternating backpressure.
    base = hs_count;
    push_op(7'h65);
    for (int i = 0; i < 12; i++) begin
      bus.cw_ready = (i % 2 == 0);
      tick();
    end
    drain();
    check("multi_beats", hs_count - base, 4);

    // Back-to-back words with no bubble.
    base = hs_count;
    base_idx = hs_cyc.size();
    bus.cw_ready = 1'b1;
    push_op(7'h01);
    push_op(7'h22);
    push_op(7'h43);
    drain();
    check("b2b_beats", hs_count - base, 6);
    if (hs_cyc.size() >= base_idx + 6)
      check("b2b_span", hs_cyc[hs_cyc.size()-1] - hs_cyc[base_idx], 5);
    else
      check("b2b_hs_count", hs_cyc.size() - base_idx, 6);

    // Fill the FIFO while stalled; the sixth opcode must wait, not vanish.
    bus.cw_ready = 1'b0;
    push_op(7'h10);
    push_op(7'h31);
    push_op(7'h52);
    push_op(7'h73);
    push_op(7'h04);
    check("full_count", bus.fifo_count, 4);
    check("full_ready", bus.op_ready, 0);
    check("full_cw_data", bus.cw_data, dec_fn(7'h10));
    bus.op_valid = 1'b1;
    bus.op_data  = 7'h15;
    tick(3);
    check("full_stall_ready", bus.op_ready, 0);
    check("full_stall_count", bus.fifo_count, 4);
    bus.cw_ready = 1'b1;
    push_op(7'h15);
    drain();

    // Flush during beat 1 with two queued opcodes.
    bus.cw_ready = 1'b0;
    push_op(7'h65);
    push_op(7'h22);
    push_op(7'h43);
    bus.cw_ready = 1'b1;
    tick();
    bus.cw_ready = 1'b0;
    check("flush_pre_beat", bus.cw_beat, 1);
    check("flush_pre_count", bus.fifo_count, 2);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_valid", bus.cw_valid, 0);
    check("flush_count", bus.fifo_count, 0);
    check("flush_beat", bus.cw_beat, 0);
    tick();
    check("flush_stays_idle", bus.cw_valid, 0);
    bus.cw_ready = 1'b1;
    push_op(7'h05);
    wait_valid("flush_reissue_valid");
    check("flush_reissue_data", bus.cw_data, 26'h0AFA5C5);
    drain();

    // Missing decoder marker sets the sticky error.
    force_mz = 1'b1;
    bus.cw_ready = 1'b0;
    push_op(7'h05);
    wait_valid("mark_valid");
    check("mark_data", bus.cw_data, 26'h02FA5C5);
    check("mark_set", bus.mark_err, 1);
    force_mz = 1'b0;
    drain();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("mark_after_flush", bus.mark_err, 1);
    push_op(7'h00);
    drain();
    check("mark_after_good", bus.mark_err, 1);
    rst = 1'b1;
    #1 check("mark_reset", bus.mark_err, 0);
    tick(2);
    rst = 1'b0;
    tick();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 800; i++) begin
      bus.op_valid = ($urandom % 2) == 0;
      bus.op_data  = 7'($urandom);
      bus.cw_ready = ($urandom % 4) != 0;
      bus.flush    = ($urandom % 60) == 0;
      tick();
    end
    bus.flush = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
